// File: rtl/psum_drain_ctrl.sv
// Drain stage for the 4-cluster psum GLBs: after compute_done rises it waits a settle delay,
// reads one output row from all four GLBs in lockstep and streams it out through a 2-entry FIFO.
module psum_drain_ctrl #(
  parameter int unsigned DATA_BITWIDTH  = 8,
  parameter int unsigned ADDR_BITWIDTH  = 10,
  parameter int unsigned X_dim          = 3,
  parameter int unsigned PSUM_LOAD_ADDR = 0,
  parameter int unsigned SETTLE_CYC     = 8,
  parameter int unsigned RELU_EN        = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       compute_done,
  input  logic                       new_layer,
  output logic                       r_req_psum,
  output logic [ADDR_BITWIDTH-1:0]   r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0]   r_data_psum_w0,
  input  logic [DATA_BITWIDTH-1:0]   r_data_psum_w1,
  input  logic [DATA_BITWIDTH-1:0]   r_data_psum_e0,
  input  logic [DATA_BITWIDTH-1:0]   r_data_psum_e1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*DATA_BITWIDTH-1:0] out_data,
  output logic                       out_col_last,
  output logic                       out_layer_last,
  output logic                       drain_busy,
  output logic                       row_done,
  output logic                       overrun_err
);

  localparam int unsigned DW = DATA_BITWIDTH;
  localparam int unsigned AW = ADDR_BITWIDTH;
  localparam int unsigned LW = 4 * DATA_BITWIDTH;
  localparam int unsigned IW = (X_dim > 1) ? $clog2(X_dim) : 1;
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(X_dim - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_READ   = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            cd_q;
  logic [SW-1:0]   set_cnt_q, set_cnt_d;
  logic [IW-1:0]   col_q, col_d;
  logic [IW-1:0]   row_q, row_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            overrun_q, overrun_d;
  logic            rdv_q;
  logic            rd_col_last_q;
  logic            rd_layer_last_q;

  logic [LW-1:0]   mem_data_q [2];
  logic            mem_cl_q   [2];
  logic            mem_ll_q   [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;

  logic            rise_c;
  logic            busy_c;
  logic            valid_c;
  logic            pop_c;
  logic [2:0]      occ_c;
  logic            issue_c;
  logic            done_c;
  logic            settle_end_c;
  logic [AW-1:0]   row_base_c;
  logic [LW-1:0]   push_data_c;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    if ((RELU_EN != 0) && x[DW-1]) return '0;
    return x;
  endfunction

  // Event and handshake decode shared by the FSM and datapath
  assign rise_c       = compute_done & ~cd_q;
  assign busy_c       = (state_q != S_IDLE);
  assign valid_c      = (fifo_cnt_q != 2'd0);
  assign pop_c        = valid_c & out_ready;
  assign settle_end_c = (state_q == S_SETTLE) && (set_cnt_q == SET_LAST);
  assign done_c       = (state_q == S_DRAIN) && (fifo_cnt_q == 2'd0) && !rdv_q;
  assign row_base_c   = AW'(PSUM_LOAD_ADDR + X_dim * 32'(row_q));
  assign push_data_c  = {relu(r_data_psum_e1), relu(r_data_psum_e0),
                         relu(r_data_psum_w1), relu(r_data_psum_w0)};

  // Credit: entries still held after this cycle's pop, plus the read whose data lands now
  assign occ_c   = 3'(fifo_cnt_q) + 3'(rdv_q) - 3'(pop_c);
  assign issue_c = (state_q == S_READ) && (occ_c < 3'd2);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rise_c) state_d = S_SETTLE;
      S_SETTLE: if (settle_end_c) state_d = S_READ;
      S_READ:   if (issue_c && (col_q == LAST_IDX)) state_d = S_DRAIN;
      S_DRAIN:  if (done_c) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    r_req_psum = 1'b0;
    drain_busy = 1'b0;
    row_done   = 1'b0;
    r_req_psum = issue_c;
    drain_busy = busy_c;
    row_done   = done_c;
  end

  // Datapath next-state: settle count, column/address walk, row index, error flag
  always_comb begin
    set_cnt_d = '0;
    col_d     = col_q;
    addr_d    = addr_q;
    row_d     = row_q;
    pend_d    = pend_q;
    overrun_d = overrun_q | (rise_c & busy_c);

    if (state_q == S_SETTLE) set_cnt_d = set_cnt_q + SW'(1);

    if (settle_end_c) begin
      col_d  = '0;
      addr_d = row_base_c;
    end else if (issue_c && (col_q != LAST_IDX)) begin
      col_d  = col_q + IW'(1);
      addr_d = addr_q + AW'(1);
    end

    // A new_layer seen while busy is held until the row finishes
    if (!busy_c) begin
      if (new_layer) row_d = '0;
    end else if (done_c) begin
      pend_d = 1'b0;
      if (pend_q || new_layer)    row_d = '0;
      else if (row_q == LAST_IDX) row_d = '0;
      else                        row_d = row_q + IW'(1);
    end else if (new_layer) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cd_q            <= 1'b0;
      set_cnt_q       <= '0;
      col_q           <= '0;
      row_q           <= '0;
      pend_q          <= 1'b0;
      addr_q          <= '0;
      overrun_q       <= 1'b0;
      rdv_q           <= 1'b0;
      rd_col_last_q   <= 1'b0;
      rd_layer_last_q <= 1'b0;
    end else begin
      cd_q      <= compute_done;
      set_cnt_q <= set_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      overrun_q <= overrun_d;
      rdv_q     <= issue_c;
      if (issue_c) begin
        rd_col_last_q   <= (col_q == LAST_IDX);
        rd_layer_last_q <= (col_q == LAST_IDX) && (row_q == LAST_IDX);
      end
    end
  end

  // 2-entry output FIFO; GLB data is captured one cycle after its request
  assign fifo_cnt_d = fifo_cnt_q + 2'(rdv_q) - 2'(pop_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
        mem_cl_q[i]   <= 1'b0;
        mem_ll_q[i]   <= 1'b0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (rdv_q) begin
        mem_data_q[wr_ptr_q] <= push_data_c;
        mem_cl_q[wr_ptr_q]   <= rd_col_last_q;
        mem_ll_q[wr_ptr_q]   <= rd_layer_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign out_valid      = valid_c;
  assign out_data       = mem_data_q[rd_ptr_q];
  assign out_col_last   = mem_cl_q[rd_ptr_q];
  assign out_layer_last = mem_ll_q[rd_ptr_q];
  assign r_addr_psum    = addr_q;
  assign overrun_err    = overrun_q;

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Bench for psum_drain_ctrl: two instances (ReLU off/on) share stimulus and are checked
// every cycle against a transaction-level model, plus hand-computed literals per scenario.
module tb_psum_drain_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 10;
  localparam int unsigned XD  = 3;
  localparam int unsigned SET = 8;

  logic          clk = 1'b0;
  logic          reset, compute_done, new_layer, out_ready;
  logic          r_req0, r_req1;
  logic [AW-1:0] r_addr0, r_addr1, glb_a0, glb_a1;
  logic [DW-1:0] w0_0, w1_0, e0_0, e1_0, w0_1, w1_1, e0_1, e1_1;
  logic          out_valid0, out_valid1, cl0, cl1, ll0, ll1;
  logic [31:0]   out_data0, out_data1;
  logic          busy0, busy1, rd0, rd1, ovr0, ovr1;

  always #5 clk = ~clk;

  psum_drain_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD), .PSUM_LOAD_ADDR(0),
                    .SETTLE_CYC(SET), .RELU_EN(0)) dut0 (
    .clk(clk), .reset(reset), .compute_done(compute_done), .new_layer(new_layer),
    .r_req_psum(r_req0), .r_addr_psum(r_addr0),
    .r_data_psum_w0(w0_0), .r_data_psum_w1(w1_0), .r_data_psum_e0(e0_0), .r_data_psum_e1(e1_0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_col_last(cl0), .out_layer_last(ll0), .drain_busy(busy0), .row_done(rd0),
    .overrun_err(ovr0));

  psum_drain_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD), .PSUM_LOAD_ADDR(0),
                    .SETTLE_CYC(SET), .RELU_EN(1)) dut1 (
    .clk(clk), .reset(reset), .compute_done(compute_done), .new_layer(new_layer),
    .r_req_psum(r_req1), .r_addr_psum(r_addr1),
    .r_data_psum_w0(w0_1), .r_data_psum_w1(w1_1), .r_data_psum_e0(e0_1), .r_data_psum_e1(e1_1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_col_last(cl1), .out_layer_last(ll1), .drain_busy(busy1), .row_done(rd1),
    .overrun_err(ovr1));

  // GLB word for an address: {e1, e0, w1, w0} = {7, 2a, -(a+1), a+1}
  function automatic logic [31:0] glb_word(input logic [AW-1:0] a);
    int v;
    v = int'(a);
    return {8'd7, 8'(2 * v), 8'(-(v + 1)), 8'(v + 1)};
  endfunction

  function automatic logic [31:0] relu4(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 4; i++) if (w[8*i+7]) r[8*i +: 8] = 8'd0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (r_req0) glb_a0 <= r_addr0;
    if (r_req1) glb_a1 <= r_addr1;
  end
  assign {e1_0, e0_0, w1_0, w0_0} = glb_word(glb_a0);
  assign {e1_1, e0_1, w1_1, w0_1} = glb_word(glb_a1);

  typedef struct { logic [AW-1:0] addr; int col; int row; } rd_t;
  typedef struct { logic [31:0] d0; logic [31:0] d1; logic cl; logic ll; int rc; } beat_t;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int n_rowdone = 0;
  rd_t   addr_q[$];
  beat_t beat_q[$];
  bit    prev_cd, busy_m, pend_m, ovr_m, lastpop_prev;
  int    row_m, issued, popped, max_out;
  bit    rise, pop, exp_valid, is_rd;
  beat_t bt;
  rd_t   ra;

  int          rise_log[$];
  int          req_cyc[$];
  logic [AW-1:0] req_addr[$];
  int          pop_cyc[$];
  logic [31:0] pop_d0[$];
  logic [31:0] pop_d1[$];
  bit          pop_ll[$];
  bit          pop_cl[$];
  int          rd_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic clear_logs();
    rise_log.delete(); req_cyc.delete(); req_addr.delete(); pop_cyc.delete();
    pop_d0.delete(); pop_d1.delete(); pop_ll.delete(); pop_cl.delete(); rd_cyc.delete();
  endtask

  // Per-cycle model and compare, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_outs0", 64'({r_req0, r_addr0, out_valid0, out_data0, cl0, ll0, busy0, rd0, ovr0}), 64'd0);
      chk("rst_outs1", 64'({r_req1, r_addr1, out_valid1, out_data1, cl1, ll1, busy1, rd1, ovr1}), 64'd0);
      addr_q.delete(); beat_q.delete();
      prev_cd = 1'b0; busy_m = 1'b0; pend_m = 1'b0; ovr_m = 1'b0; lastpop_prev = 1'b0;
      row_m = 0; issued = 0; popped = 0;
    end else begin
      cyc_n++;
      rise = compute_done && !prev_cd;
      exp_valid = (beat_q.size() > 0) && (beat_q[0].rc <= cyc_n - 2);
      chk("valid0", 64'(out_valid0), 64'(exp_valid));
      chk("valid1", 64'(out_valid1), 64'(exp_valid));
      if (exp_valid) begin
        chk("data0", 64'(out_data0), 64'(beat_q[0].d0));
        chk("data1_relu", 64'(out_data1), 64'(beat_q[0].d1));
        chk("tags0", 64'({cl0, ll0}), 64'({beat_q[0].cl, beat_q[0].ll}));
        chk("tags1", 64'({cl1, ll1}), 64'({beat_q[0].cl, beat_q[0].ll}));
      end
      is_rd = lastpop_prev;
      chk("row_done0", 64'(rd0), 64'(is_rd));
      chk("row_done1", 64'(rd1), 64'(is_rd));
      chk("busy0", 64'(busy0), 64'(busy_m));
      chk("busy1", 64'(busy1), 64'(busy_m));
      chk("overrun0", 64'(ovr0), 64'(ovr_m));
      chk("overrun1", 64'(ovr1), 64'(ovr_m));

      pop = exp_valid && out_ready;
      lastpop_prev = 1'b0;
      if (pop) begin
        bt = beat_q.pop_front();
        popped++;
        lastpop_prev = bt.cl;
        pop_cyc.push_back(cyc_n); pop_d0.push_back(out_data0); pop_d1.push_back(out_data1);
        pop_cl.push_back(cl0); pop_ll.push_back(ll0);
      end

      if (r_req0) begin
        if (addr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_req: got addr %0d want no request (cycle %0d)", r_addr0, cyc_n);
        end else begin
          ra = addr_q.pop_front();
          chk("req_addr", 64'(r_addr0), 64'(ra.addr));
          bt.d0 = glb_word(ra.addr);
          bt.d1 = relu4(glb_word(ra.addr));
          bt.cl = (ra.col == XD - 1);
          bt.ll = (ra.col == XD - 1) && (ra.row == XD - 1);
          bt.rc = cyc_n;
          beat_q.push_back(bt);
          issued++;
          req_cyc.push_back(cyc_n); req_addr.push_back(r_addr0);
        end
      end
      if (issued - popped > max_out) max_out = issued - popped;
      chk("outstanding_le2", 64'(issued - popped <= 2), 64'd1);

      if (new_layer) begin
        if (busy_m) pend_m = 1'b1;
        else        row_m = 0;
      end
      if (rise) begin
        rise_log.push_back(cyc_n);
        if (busy_m) ovr_m = 1'b1;
        else begin
          busy_m = 1'b1;
          for (int c = 0; c < XD; c++) begin
            ra.addr = AW'(row_m * XD + c); ra.col = c; ra.row = row_m;
            addr_q.push_back(ra);
          end
        end
      end
      if (is_rd) begin
        rd_cyc.push_back(cyc_n);
        n_rowdone++;
        busy_m = 1'b0;
        row_m  = pend_m ? 0 : (row_m + 1) % XD;
        pend_m = 1'b0;
      end
      prev_cd = compute_done;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_drain();
    compute_done = 1'b0;
    cyc(1);
    compute_done = 1'b1;
    cyc(1);
  endtask

  task automatic wait_rows(input int target, input int budget, input string nm);
    int b;
    b = 0;
    while (n_rowdone < target && b < budget) begin cyc(1); b++; end
    chk(nm, 64'(n_rowdone >= target), 64'd1);
  endtask

  task automatic wait_first_req(input int budget);
    int b;
    b = 0;
    while (req_cyc.size() == 0 && b < budget) begin cyc(1); b++; end
    chk("first_req_seen", 64'(req_cyc.size() > 0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tgt;
    reset = 1'b1; compute_done = 1'b0; new_layer = 1'b0; out_ready = 1'b1;
    max_out = 0;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // Reset asserted while reads are being issued
    clear_logs();
    start_drain();
    wait_first_req(40);
    #2;
    reset = 1'b1; compute_done = 1'b0;
    #1;
    chk("async_rst_dut0", 64'({r_req0, r_addr0, out_valid0, out_data0, busy0, rd0, ovr0}), 64'd0);
    chk("async_rst_dut1", 64'({r_req1, r_addr1, out_valid1, out_data1, busy1, rd1, ovr1}), 64'd0);
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // Clean row 0 with ready held high
    clear_logs();
    tgt = n_rowdone + 1;
    start_drain();
    wait_rows(tgt, 100, "t2_row_done_timeout");
    chk("t2_nreq", 64'(req_cyc.size()), 64'd3);
    chk("t2_npop", 64'(pop_cyc.size()), 64'd3);
    if (req_cyc.size() == 3 && pop_cyc.size() == 3 && rise_log.size() > 0 && rd_cyc.size() > 0) begin
      chk("t2_settle_gap", 64'(req_cyc[0] - rise_log[0]), 64'(SET + 1));
      chk("t2_addrs", 64'({req_addr[0], req_addr[1], req_addr[2]}), 64'({10'd0, 10'd1, 10'd2}));
      chk("t2_beat0", 64'(pop_d0[0]), 64'h0700FF01);
      chk("t2_beat1", 64'(pop_d0[1]), 64'h0702FE02);
      chk("t2_beat2", 64'(pop_d0[2]), 64'h0704FD03);
      chk("t2_relu0", 64'(pop_d1[0]), 64'h07000001);
      chk("t2_relu1", 64'(pop_d1[1]), 64'h07020002);
      chk("t2_relu2", 64'(pop_d1[2]), 64'h07040003);
      chk("t2_col_last", 64'({pop_cl[0], pop_cl[1], pop_cl[2]}), 64'b001);
      chk("t2_back2back", 64'({pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]}), {32'd1, 32'd1});
      chk("t2_row_done_lat", 64'(rd_cyc[0] - pop_cyc[2]), 64'd1);
    end
    chk("t2_idle_busy", 64'(busy0), 64'd0);

    // Rows 1 and 2 complete the layer
    clear_logs();
    tgt = n_rowdone + 1;
    start_drain();
    wait_rows(tgt, 100, "t3_row1_timeout");
    tgt = n_rowdone + 1;
    start_drain();
    wait_rows(tgt, 100, "t3_row2_timeout");
    chk("t3_npop", 64'(pop_cyc.size()), 64'd6);
    if (pop_cyc.size() == 6 && req_addr.size() == 6) begin
      chk("t3_addr_first", 64'(req_addr[0]), 64'd3);
      chk("t3_addr_last", 64'(req_addr[5]), 64'd8);
      chk("t3_layer_last", 64'({pop_ll[5], pop_ll[4], pop_ll[3], pop_ll[2], pop_ll[1], pop_ll[0]}),
          64'b100000);
      chk("t3_addr8_beat", 64'(pop_d0[5]), 64'h0710F709);
    end

    // Backpressure mid-row after the row index wrapped
    clear_logs();
    tgt = n_rowdone + 1;
    start_drain();
    begin
      int b;
      b = 0;
      while (pop_cyc.size() == 0 && b < 40) begin cyc(1); b++; end
    end
    out_ready = 1'b0;
    cyc(5);
    out_ready = 1'b1;
    wait_rows(tgt, 100, "t4_row_done_timeout");
    chk("t4_npop", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3 && req_addr.size() == 3) begin
      chk("t4_wrap_addr", 64'(req_addr[0]), 64'd0);
      chk("t4_order", 64'({pop_d0[0][7:0], pop_d0[1][7:0], pop_d0[2][7:0]}), 64'h010203);
      chk("t4_stall_gap", 64'(pop_cyc[1] - pop_cyc[0]), 64'd6);
    end
    chk("t4_max_outstanding", 64'(max_out <= 2), 64'd1);

    // Overrun and new_layer while busy
    clear_logs();
    tgt = n_rowdone + 1;
    start_drain();
    wait_first_req(40);
    compute_done = 1'b0;
    cyc(1);
    compute_done = 1'b1; new_layer = 1'b1;
    cyc(1);
    new_layer = 1'b0;
    wait_rows(tgt, 100, "t6_row_done_timeout");
    chk("t6_overrun0", 64'(ovr0), 64'd1);
    chk("t6_overrun1", 64'(ovr1), 64'd1);
    chk("t6_npop", 64'(pop_cyc.size()), 64'd3);
    if (req_addr.size() == 3) chk("t6_row1_addrs", 64'({req_addr[0], req_addr[2]}), 64'({10'd3, 10'd5}));
    clear_logs();
    tgt = n_rowdone + 1;
    start_drain();
    wait_rows(tgt, 100, "t6_next_row_timeout");
    if (req_addr.size() > 0) chk("t6_new_layer_addr", 64'(req_addr[0]), 64'd0);
    chk("t6_overrun_sticky", 64'(ovr0), 64'd1);

    // Random ready and occasional new_layer, checked by the model
    for (int k = 0; k < 6; k++) begin
      int b;
      tgt = n_rowdone + 1;
      start_drain();
      b = 0;
      while (n_rowdone < tgt && b < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        new_layer = ($urandom_range(0, 7) == 0);
        cyc(1);
        b++;
      end
      out_ready = 1'b1; new_layer = 1'b0;
      chk("rand_row_done", 64'(n_rowdone >= tgt), 64'd1);
    end
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
